// File: rtl/vj_onchip_mem_arbiter.sv
// Two-master arbiter in front of the 1024x32 single-port on-chip RAM, with lock for atomic RMW.
// Optional performance counters are enabled by defining VJ_MEMARB_PERF_CNT_EN.
module vj_onchip_mem_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                reset_n,
`ifdef VJ_MEMARB_PERF_CNT_EN
  input  logic                perf_clr,
  output logic [31:0]         m0_stall_cnt,
  output logic [31:0]         m1_stall_cnt,
  output logic [31:0]         gnt_cnt,
`endif
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic                m0_lock,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic                m1_lock,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  typedef enum logic [1:0] {StArb, StLock0, StLock1} state_e;

  state_e state_q, state_d;
  logic   last_gnt_q, last_gnt_d;
  logic   rd_pend_q, rd_pend_d;
  logic   rd_tag_q, rd_tag_d;

  logic req0, req1;
  logic gnt0, gnt1;
  logic any_gnt, gnt_write;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Nothing is accepted while reset is held, so no transfer can leak out of reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      case (state_q)
        StLock0: gnt0 = req0;
        StLock1: gnt1 = req1;
        default: begin
          if (req0 && req1) begin
            if (FIXED_PRIO != 0 || last_gnt_q) gnt0 = 1'b1;
            else                               gnt1 = 1'b1;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
      endcase
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign gnt_write = (gnt0 & m0_write) | (gnt1 & m1_write);

  always_comb begin
    state_d    = state_q;
    last_gnt_d = any_gnt ? gnt1 : last_gnt_q;
    // Write wins over read when both are raised, so only pure reads return data.
    rd_pend_d  = any_gnt & ~gnt_write;
    rd_tag_d   = gnt1;
    case (state_q)
      StArb: begin
        if (gnt0 && m0_lock)      state_d = StLock0;
        else if (gnt1 && m1_lock) state_d = StLock1;
      end
      StLock0: if (gnt0 && !m0_lock) state_d = StArb;
      StLock1: if (gnt1 && !m1_lock) state_d = StArb;
      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StArb;
      last_gnt_q <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_tag_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

  always_comb begin
    m0_waitrequest   = reset_n & req0 & ~gnt0;
    m1_waitrequest   = reset_n & req1 & ~gnt1;
    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;
    m0_readdatavalid = rd_pend_q & ~rd_tag_q;
    m1_readdatavalid = rd_pend_q & rd_tag_q;
    mem_address      = '0;
    mem_byteenable   = '0;
    mem_writedata    = '0;
    // Idle cycles present master 0 on the bus with chipselect low.
    if (reset_n) begin
      mem_address    = gnt1 ? m1_address    : m0_address;
      mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
      mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
    end
    mem_chipselect   = any_gnt;
    mem_write        = gnt_write;
    mem_clken        = reset_n;
  end

`ifdef VJ_MEMARB_PERF_CNT_EN
  logic [31:0] m0_stall_q, m1_stall_q, gnt_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_stall_q <= '0;
      m1_stall_q <= '0;
      gnt_cnt_q  <= '0;
    end else if (perf_clr) begin
      m0_stall_q <= '0;
      m1_stall_q <= '0;
      gnt_cnt_q  <= '0;
    end else begin
      if (m0_waitrequest && m0_stall_q != '1) m0_stall_q <= m0_stall_q + 32'd1;
      if (m1_waitrequest && m1_stall_q != '1) m1_stall_q <= m1_stall_q + 32'd1;
      if (any_gnt && gnt_cnt_q != '1)         gnt_cnt_q  <= gnt_cnt_q + 32'd1;
    end
  end

  assign m0_stall_cnt = m0_stall_q;
  assign m1_stall_cnt = m1_stall_q;
  assign gnt_cnt      = gnt_cnt_q;
`endif

endmodule

// File: doc/vj_onchip_mem_arbiter.md
Name: vj_onchip_mem_arbiter

Overview:
- Two-master arbiter in front of the 1024x32 single-port on-chip RAM (altsyncram, address registered, output unregistered, read latency 1).
- Master 0: Nios II data master. Master 1: Viola-Jones integral-image/feature-fetch engine.
- Grants at most one transfer per cycle, returns read data with readdatavalid to the issuing master, and supports a lock for atomic read-modify-write sequences.

Parameters:
- ADDR_W, 10, word address width (1024 words).
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins a simultaneous request.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- mN_address  in  ADDR_W  master N (N=0,1) word address.
- mN_byteenable  in  DATA_W/8  master N byte lanes.
- mN_read  in  1  master N read request.
- mN_write  in  1  master N write request.
- mN_lock  in  1  master N holds ownership after this transfer.
- mN_writedata  in  DATA_W  master N write data.
- mN_waitrequest  out  1  master N transfer not accepted this cycle.
- mN_readdata  out  DATA_W  master N read data.
- mN_readdatavalid  out  1  mN_readdata valid.
- mem_address  out  ADDR_W  to RAM address.
- mem_byteenable  out  DATA_W/8  to RAM byteenable.
- mem_chipselect  out  1  to RAM chipselect.
- mem_write  out  1  to RAM write.
- mem_writedata  out  DATA_W  to RAM writedata.
- mem_clken  out  1  to RAM clken.
- mem_readdata  in  DATA_W  from RAM readdata.

Behaviour:
- Request: reqN = mN_read | mN_write. mN_read and mN_write both high is illegal; write takes precedence.
- Grant is combinational from reqN, the lock state and the registered last-grant pointer (last_gnt, reset 1 so master 0 wins first).
- The accepted master sees waitrequest=0. Any other requesting master sees waitrequest=1. A master with no request sees waitrequest=0.
- Mem outputs mux the granted master's address, byteenable and writedata.
- mem_chipselect = any grant. mem_write = granted write. Idle cycles drive address/byteenable/writedata from master 0 with chipselect=0.
- mem_clken = 1 whenever reset_n = 1; 0 while reset_n = 0.
- Read return:
  - On an accepted read in cycle T, register rd_pend=1 and rd_tag=N.
  - In cycle T+1, mN_readdatavalid=1 for tag N and mN_readdata = mem_readdata. The other master's readdatavalid stays 0.
  - Back-to-back reads from either master run at one per cycle with no bubble.
- Both mN_readdata outputs carry mem_readdata unconditionally; readdatavalid qualifies them.
- Round-robin (FIXED_PRIO=0): on a simultaneous request, the master not equal to last_gnt wins. last_gnt updates on every accepted transfer.
- Lock FSM (registered state, reset ARB):
  - ARB: normal arbitration. An accepted transfer with mN_lock=1 moves to LOCK_N.
  - LOCK_N: only master N is granted; the other master's requests are held (waitrequest=1).
  - An accepted master-N transfer with mN_lock=0 returns to ARB in the next cycle; that transfer itself completes normally.
  - Lock has no timeout. Master N idling in LOCK_N keeps the lock.
- Reset (async, any time) clears state to ARB, last_gnt to 1, rd_pend to 0 and both readdatavalid to 0. A read accepted in the cycle reset asserts never returns data.
- Outputs at reset: waitrequest 0, readdatavalid 0, mem_chipselect 0, mem_write 0, mem_clken 0, mem_address 0, mem_byteenable 0, mem_writedata 0.
- A write followed by a read to the same address in the next cycle returns the new data (single-port RAM ordering; no extra hazard logic).

Optional Feature:
- Macro VJ_MEMARB_PERF_CNT_EN.
- Defined: adds outputs m0_stall_cnt[31:0], m1_stall_cnt[31:0], gnt_cnt[31:0] and input perf_clr.
  - mN_stall_cnt increments each cycle reqN=1 and mN_waitrequest=1.
  - gnt_cnt increments per accepted transfer.
  - All counters saturate at 0xFFFFFFFF, clear on reset or perf_clr=1 (perf_clr has priority over increment).
- Undefined: none of these ports or registers exist; arbitration is identical.

Test Plan:
- Single master: m0 writes 0xDEADBEEF to addr 0x005 (be=0xF), then reads addr 0x005 → waitrequest 0 both cycles; m0_readdatavalid=1 with 0xDEADBEEF exactly one cycle after the read; m1_readdatavalid stays 0.
- Contention, round-robin: m0 and m1 both read continuously for 6 cycles from reset → grants alternate m0,m1,m0,m1,m0,m1; each master sees 3 waitrequest cycles; readdatavalid tags match the issuer.
- FIXED_PRIO=1: same stimulus → m0 granted all 6 cycles; m1 waitrequest=1 throughout; m1 granted in the first cycle m0 drops its request.
- Lock: m1 read addr 0x3FF with lock=1, then write with lock=0 while m0 requests continuously → m0 held both cycles; m0 granted in the cycle after m1's unlocked write.
- Reset mid-read: assert reset_n=0 in the cycle after m0 read acceptance → m0_readdatavalid 0; after release, the first simultaneous request goes to m0.
- Byte lanes: m1 writes 0x11223344 with be=0x2 over 0xFFFFFFFF at addr 0x100, then reads it back → 0xFFFF33FF. With VJ_MEMARB_PERF_CNT_EN defined, gnt_cnt reads 2.
